// File: rtl/inst_fetch.sv
// Instruction fetch: pc + 2-entry {pc,inst} FIFO, 1-cycle read-to-valid latency; fetch stalls when full without a pop.
// Redirect flushes and reloads pc; INST_FETCH_PERF_EN adds fetch_count/flush_count outputs.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [31:0] PC_MASK = 32'(MEM_WORDS * 4 - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] last_addr;
    logic [1:0]  occ;
    entry_t      fifo0, fifo1, new_entry;
    logic        push, pop;
    logic [31:0] pc_word;
    logic [31:0] redirect_tgt;
    logic [1:0]  occ_nxt;

    assign pc_word      = pc >> 2;
    assign redirect_tgt = redirect_pc & ~32'h3 & PC_MASK;
    assign new_entry    = '{pc: pc, data: mem_rdata};

    assign inst_valid = (occ != 2'd0);
    assign inst_data  = fifo0.data;
    assign inst_pc    = fifo0.pc;

    // rst_n gates the read so mem_re is low throughout reset, not just after the first edge
    assign pop    = inst_valid && inst_ready && !redirect_valid;
    assign mem_re = rst_n && en && !redirect_valid &&
                    ((occ < 2'd2) || (occ == 2'd2 && pop));
    assign push   = mem_re;
    assign mem_addr = mem_re ? pc_word : last_addr;

    always_comb begin
        occ_nxt = occ;
        if (redirect_valid)
            occ_nxt = 2'd0;
        else if (push && !pop)
            occ_nxt = occ + 2'd1;
        else if (pop && !push)
            occ_nxt = occ - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        if (!en)
            state_nxt = IDLE;
        else if (redirect_valid)
            state_nxt = RUN;
        else begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     if (occ_nxt == 2'd2 && !pop) state_nxt = FULL;
                FULL:    if (pop) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            last_addr <= 32'h0;
            occ       <= 2'd0;
            fifo0     <= '0;
            fifo1     <= '0;
        end else begin
            occ <= occ_nxt;
            if (push)
                last_addr <= pc_word;
            if (redirect_valid) begin
                pc <= redirect_tgt;
            end else begin
                if (push)
                    pc <= (pc + 32'd4) & PC_MASK;
                // head is always fifo0; a pop shifts fifo1 down, a push fills the first free slot
                case ({push, pop})
                    2'b10: begin
                        if (occ == 2'd0) fifo0 <= new_entry;
                        else             fifo1 <= new_entry;
                    end
                    2'b01: fifo0 <= fifo1;
                    2'b11: begin
                        if (occ == 2'd1) begin
                            fifo0 <= new_entry;
                        end else begin
                            fifo0 <= fifo1;
                            fifo1 <= new_entry;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef INST_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
            flush_count <= 32'h0;
        end else begin
            if (push)
                fetch_count <= fetch_count + 32'd1;
            if (redirect_valid && inst_valid)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
